// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB/I2C register-bank target.
package sccb_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;
  localparam int REG_N  = 256;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h21;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_SUB,
    S_SUB_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/sccb_sync_edge.sv
// Two-flop synchronizer for a raw bus pin, with rise/fall pulses.
module sccb_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  // Pins idle high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target with a 256x8 register file and a host read port.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              busy,
  output logic              reg_wr,
  output logic [BYTE_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  input  logic [BYTE_W-1:0] host_addr,
  output logic [BYTE_W-1:0] host_rdata
);

  state_t state, state_nxt;

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start, stop, last_bit, ack_done;
  logic rw, wr_en;
  logic [CNT_W-1:0]  cnt;
  logic [BYTE_W-1:0] sh, ptr, byte_in, rd_byte;
  logic [BYTE_W-1:0] mem [REG_N];

  sccb_sync_edge u_scl (
    .clk   (clk),
    .reset (reset),
    .din   (scl_in),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  sccb_sync_edge u_sda (
    .clk   (clk),
    .reset (reset),
    .din   (sda_in),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start    = sda_fall & scl;
  assign stop     = sda_rise & scl;
  assign byte_in  = {sh[6:0], sda};
  assign last_bit = scl_rise && (cnt == 4'd7);
  assign ack_done = scl_fall && (cnt == 4'd1);
  assign rd_byte  = mem[ptr];

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_ADDR;
    end else if (stop) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_ADDR:
          if (last_bit)
            state_nxt = (byte_in[7:1] == DEV_ADDR) ?
                        S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:
          if (ack_done)
            state_nxt = rw ? S_RDATA : S_SUB;
        S_SUB:
          if (last_bit) state_nxt = S_SUB_ACK;
        S_SUB_ACK:
          if (ack_done) state_nxt = S_WDATA;
        S_WDATA:
          if (last_bit) state_nxt = S_WDATA_ACK;
        S_WDATA_ACK:
          if (ack_done) state_nxt = S_WDATA;
        S_RDATA:
          if (scl_fall && cnt == 4'd7)
            state_nxt = S_RDATA_ACK;
        S_RDATA_ACK:
          if (scl_rise && cnt == 4'd0 && sda)
            state_nxt = S_IGNORE;
          else if (ack_done)
            state_nxt = S_RDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (state != S_IDLE);
    reg_wr = wr_en;
  end

  // In RDATA, sh holds the bits still to be driven, MSB first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      sh        <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        cnt <= '0;
      end else if (stop) begin
        cnt    <= '0;
        sda_oe <= 1'b0;
      end else begin
        unique case (state)
          S_ADDR, S_SUB, S_WDATA:
            if (scl_rise) begin
              sh  <= byte_in;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                cnt <= '0;
                if (state == S_ADDR) rw <= byte_in[0];
                if (state == S_SUB) ptr <= byte_in;
                if (state == S_WDATA) begin
                  wr_en     <= 1'b1;
                  reg_addr  <= ptr;
                  reg_wdata <= byte_in;
                  ptr       <= ptr + 8'd1;
                end
              end
            end
          S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK:
            if (scl_fall) begin
              if (cnt == 4'd0) begin
                sda_oe <= 1'b1;
                cnt    <= 4'd1;
              end else begin
                cnt <= '0;
                if (state == S_ADDR_ACK && rw) begin
                  sh     <= {rd_byte[6:0], 1'b0};
                  sda_oe <= ~rd_byte[7];
                end else begin
                  sda_oe <= 1'b0;
                end
              end
            end
          S_RDATA:
            if (scl_fall) begin
              if (cnt == 4'd7) begin
                sda_oe <= 1'b0;
                cnt    <= '0;
              end else begin
                sda_oe <= ~sh[7];
                sh     <= {sh[6:0], 1'b0};
                cnt    <= cnt + 4'd1;
              end
            end
          S_RDATA_ACK:
            if (scl_rise && cnt == 4'd0 && !sda) begin
              ptr <= ptr + 8'd1;
              cnt <= 4'd1;
            end else if (ack_done) begin
              sh     <= {rd_byte[6:0], 1'b0};
              sda_oe <= ~rd_byte[7];
              cnt    <= '0;
            end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) mem[i] <= '0;
      host_rdata <= '0;
    end else begin
      if (wr_en) mem[reg_addr] <= reg_wdata;
      host_rdata <= mem[host_addr];
    end
  end

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB/I2C target (responder) with a 256 x 8 register file, the bus-opposite end of the camera I2C master. Samples SCL/SDA on the system clock, decodes START/STOP, device address, sub-address, burst writes and burst reads, and drives SDA open-drain. Used as a camera register-bank emulator on the camsda/camscl pins in bench and loopback builds. Also serves as a host-visible configuration mailbox.

## Interface
- DEV_ADDR, 7'h21, 7-bit device address this target answers to.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low.
- scl_in  in  1  raw SCL pin level (asynchronous).
- sda_in  in  1  raw SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (external pull-up).
- busy  out  1  high from detected START to detected STOP.
- reg_wr  out  1  one-cycle pulse per register written by the bus.
- reg_addr  out  8  register index of the current/last bus write.
- reg_wdata  out  8  data of the current/last bus write.
- host_addr  in  8  host read index.
- host_rdata  out  8  reg[host_addr], registered.

## Operation
- SCL/SDA each pass a 2-FF synchronizer; previous synced value kept for edge detect.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both override any state.
- States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START (incl. repeated) -> ADDR, bit counter 0, busy=1. STOP -> IDLE, sda_oe=0, busy=0.
- ADDR/SUB/WDATA: shift SDA MSB first on each SCL rising edge; 8th bit completes the byte.
- ADDR byte: [7:1]==DEV_ADDR -> ADDR_ACK; else IGNORE (no drive until START/STOP).
- ACK: sda_oe=1 on the SCL falling edge ending bit 8; sda_oe=0 on the next SCL falling edge.
- R/W=0: ADDR_ACK -> SUB; sub-address byte loads pointer, SUB_ACK -> WDATA. Each WDATA byte: reg[ptr]<=byte, reg_wr pulse, reg_addr=ptr, reg_wdata=byte, ptr<=ptr+1 (255 wraps to 0), WDATA_ACK -> WDATA.
- R/W=1: load shift register with reg[ptr] on the falling edge ending ADDR_ACK; drive MSB immediately (sda_oe = ~bit), next bits on following SCL falling edges.
- After bit 8 release SDA; RDATA_ACK samples master on 9th SCL rise: 0 -> ptr+1, reload, RDATA; 1 (NACK) -> IGNORE.
- Pointer persists across STOP/START (SCCB 2-phase read: write sub-address, STOP, read).
- host read port independent of bus; same-cycle bus write and host read of same index returns old data.

## Timing
- Pin-to-decision latency: 3 clk (2 sync + 1 edge register). clk must be >= 16x SCL frequency.
- sda_oe changes exactly 1 clk after the detected SCL falling edge; never changes while synced SCL high (except reset/STOP release).
- reg_wr: 1 clk after the 8th data-bit rising edge is detected; high 1 cycle.
- host_rdata: 1 clk latency.
- Reset values: sda_oe 0, busy 0, reg_wr 0, reg_addr 0, reg_wdata 0, host_rdata 0, ptr 0, all registers 0, state IDLE. Reset mid-transfer releases SDA on the next clk.
- Own SDA drive happens only while SCL low, so never self-detects START/STOP.

## Structure
- Package sccb_pkg: state encoding constants, default DEV_ADDR, byte/bit-count widths.
- Sub-module sccb_sync_edge: 2-FF synchronizer plus rise/fall pulses; instantiated for SCL and SDA.
- Register file inferred as distributed RAM, one write port, two read ports (bus, host).

## Test plan
- Write 0x42, sub 0x12, data 0x80 -> three ACKs, reg_wr pulse with reg_addr 0x12, reg_wdata 0x80; host_addr 0x12 returns 0x80.
- Write 0x44 (wrong address) followed by two bytes -> sda_oe never asserted, no reg_wr, busy high until STOP.
- Burst write sub 0xFE, data 0x11,0x22,0x33 -> reg[0xFE]=0x11, reg[0xFF]=0x22, reg[0x00]=0x33 (wrap).
- Write sub 0x0A, STOP, START, 0x43, read 2 bytes ACK then NACK -> bus returns reg[0x0A], reg[0x0B]; ptr ends 0x0B; SDA released after NACK.
- Repeated START after sub-address, then read -> read starts at sub-address without STOP.
- reset low during read data bit driven low -> sda_oe 0 next clk, busy 0, state IDLE; next transaction completes normally.
